// File: rtl/io_pkg.sv
// Shared encodings for the UART I/O arbiter: FSM states, core op codes, mode values, loader sync byte.
package io_pkg;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_IN_WAIT,
    CORE_OUT_WAIT
  } core_state_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_LAUNCH,
    DRAIN_HOLD
  } drain_state_t;

  localparam logic       IO_IN     = 1'b0;
  localparam logic       IO_OUT    = 1'b1;
  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_EXEC = 3'd2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, 2**AW x W, head visible combinationally on dout (0-cycle read).
// Push to a full FIFO is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_io_arbiter.sv
// Bridges core IN/OUT requests to uart rx/tx byte queues; IN acks 2 cycles after request when data is waiting.
// Core stalls (busy) on empty rx or full tx queue; tx drain waits on tx_busy; rx overflow drops and flags.
module uart_io_arbiter
  import io_pkg::*;
#(
  parameter int RX_AW = 10,
  parameter int TX_AW = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  mode,
  input  logic        core_req,
  input  logic        core_op,
  input  logic [7:0]  core_wdata,
  output logic        core_ack,
  output logic [31:0] core_rdata,
  output logic        busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        aa_sent,
  output logic        rx_overflow
);

  core_state_t  core_state, core_next;
  drain_state_t drain_state, drain_next;

  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_din, tx_dout;
  logic       aa_queued, loader_pend, loader_push;
  logic       core_out_push, in_done, ack_now;

  assign rx_push     = rx_valid && (mode == MODE_EXEC);
  assign loader_pend = (mode == MODE_LOAD) && !aa_queued;
  assign loader_push = loader_pend && !tx_full;
  assign tx_push     = loader_push | core_out_push;
  assign tx_din      = loader_push ? SYNC_BYTE : core_wdata;
  assign ack_now     = in_done | core_out_push;
  assign busy        = core_req & ~core_ack;

  sync_fifo #(.AW(RX_AW), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // core_ack is registered, so IDLE must ignore the request still held during the ack cycle.
  always_comb begin
    core_next     = core_state;
    rx_pop        = 1'b0;
    in_done       = 1'b0;
    core_out_push = 1'b0;
    case (core_state)
      CORE_IDLE: begin
        if (core_req && !core_ack)
          core_next = (core_op == IO_OUT) ? CORE_OUT_WAIT : CORE_IN_WAIT;
      end
      CORE_IN_WAIT: begin
        if (!rx_empty) begin
          rx_pop    = 1'b1;
          in_done   = 1'b1;
          core_next = CORE_IDLE;
        end
      end
      CORE_OUT_WAIT: begin
        if (!tx_full && !loader_pend) begin
          core_out_push = 1'b1;
          core_next     = CORE_IDLE;
        end
      end
      default: core_next = CORE_IDLE;
    endcase
  end

  always_comb begin
    drain_next = drain_state;
    tx_pop     = 1'b0;
    case (drain_state)
      DRAIN_IDLE:   if (!tx_busy && !tx_empty) drain_next = DRAIN_LAUNCH;
      DRAIN_LAUNCH: begin
        tx_pop     = 1'b1;
        drain_next = DRAIN_HOLD;
      end
      DRAIN_HOLD:   drain_next = DRAIN_IDLE;
      default:      drain_next = DRAIN_IDLE;
    endcase
  end

  // Head is stable through LAUNCH because the pop only takes effect on exit.
  assign tx_start = (drain_state == DRAIN_LAUNCH);
  assign tx_data  = tx_start ? tx_dout : 8'h00;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      core_state  <= CORE_IDLE;
      drain_state <= DRAIN_IDLE;
      core_ack    <= 1'b0;
      core_rdata  <= 32'h0;
      aa_queued   <= 1'b0;
      aa_sent     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      core_state  <= core_next;
      drain_state <= drain_next;
      core_ack    <= ack_now;
      if (in_done) core_rdata <= {24'h0, rx_dout};
      if (loader_push) aa_queued <= 1'b1;
      if (aa_queued && tx_empty && (drain_state == DRAIN_IDLE) && !tx_busy) aa_sent <= 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/uart_io_arbiter.md
UART_IO_ARBITER -- requirements
Module: uart_io_arbiter

Interface
REQ-001 Parameters SHALL be: RX_AW, default 10, rx FIFO address width (depth 2**RX_AW); TX_AW, default 8, tx FIFO address width (depth 2**TX_AW).
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- mode  in  3  1=LOAD, 2=EXEC, others idle
- core_req  in  1  core I/O request, held until core_ack
- core_op  in  1  0=IN, 1=OUT
- core_wdata  in  8  OUT byte
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  32  IN result
- busy  out  1  core stall
- rx_valid  in  1  uart_rx byte strobe
- rx_data  in  8  received byte
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  uart_tx launch pulse
- tx_busy  in  1  uart_tx busy
- aa_sent  out  1  loader sync byte fully transmitted (sticky)
- rx_overflow  out  1  sticky rx drop flag

Function
REQ-003 The rx FIFO SHALL push rx_data when rx_valid=1 and mode=2; bytes received in any other mode SHALL be discarded.
REQ-004 A push to a full rx FIFO SHALL be dropped and SHALL set rx_overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-005 The core FSM SHALL have states IDLE, IN_WAIT and OUT_WAIT; IDLE SHALL go to IN_WAIT or OUT_WAIT on core_req, selected by core_op.
REQ-006 In IN_WAIT the FSM SHALL wait while the rx FIFO is empty.
- When non-empty: pop the head, register core_rdata={24'b0,byte}, pulse core_ack for one cycle, return to IDLE.
- Minimum latency: core_ack SHALL rise 2 cycles after core_req is first seen high.
REQ-007 In OUT_WAIT the FSM SHALL wait while the tx FIFO is full or a loader push is pending.
- Otherwise: push core_wdata, pulse core_ack, return to IDLE.
REQ-008 busy SHALL equal (core_req & ~core_ack), combinationally.
REQ-009 core_rdata SHALL hold its value until the next IN completion.
REQ-010 When mode=1 and the loader has not yet queued 0xAA, the block SHALL push 0xAA once.
- The loader push SHALL take priority over a same-cycle core OUT push.
REQ-011 aa_sent SHALL set once, after 0xAA has been queued, the tx FIFO is empty, the drain FSM is IDLE and tx_busy=0.
- aa_sent SHALL clear only on reset.
REQ-012 The drain FSM SHALL have states IDLE, LAUNCH and HOLD.
- IDLE: go to LAUNCH when ~tx_busy and the tx FIFO is non-empty.
- LAUNCH: tx_start=1 for exactly one cycle, tx_data=FIFO head; pop the head on exit.
- HOLD: one cycle, to let tx_busy rise; then IDLE.
REQ-013 tx_data SHALL remain stable during LAUNCH.
- Bytes SHALL be transmitted in push order.
REQ-014 FIFO pointers SHALL wrap modulo depth.
- Full/empty SHALL be distinguished with one extra pointer bit.
REQ-015 A simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged.
REQ-016 A mode change SHALL NOT abort an in-progress core request or transmission.

Reset
REQ-017 On rstn=0 at a clk edge the block SHALL:
- clear all FIFO pointers;
- return both FSMs to IDLE;
- force core_ack=0, tx_start=0, tx_data=0, core_rdata=0, aa_sent=0, rx_overflow=0;
- clear the loader-queued flag.
REQ-018 A reset during LAUNCH SHALL drop tx_start in the following cycle; FIFO contents SHALL be discarded.

Structure
REQ-019 Package io_pkg SHALL hold:
- the core and drain FSM state enums;
- the core_op encodings IO_IN=0 and IO_OUT=1;
- SYNC_BYTE=8'hAA;
- the MODE_LOAD=1 and MODE_EXEC=2 constants.
REQ-020 Both queues SHALL be instances of one sub-module, sync_fifo.
- Parameters: address width AW, data width W.
- Ports: push, pop, din, dout, full, empty.

Verification
REQ-021 Reset, then mode=1, tx_busy modelled 20 cycles per byte -> exactly one tx_start with tx_data=0xAA; aa_sent=1 once tx_busy falls and never clears.
REQ-022 mode=2, rx bytes 0x41, 0x42, then two IN requests -> core_rdata 0x00000041 then 0x00000042; each core_ack is a single cycle.
REQ-023 IN request with rx FIFO empty -> busy=1 for 50 cycles; rx_valid with 0x07 -> core_ack within 2 cycles, core_rdata=0x00000007.
REQ-024 RX_AW=2, push 5 bytes without popping -> bytes 1-4 retained in order, 5th dropped, rx_overflow=1.
REQ-025 TX_AW=2, tx_busy held high, 5 OUT requests 0x10..0x14 -> the 5th stalls (busy=1); release tx_busy -> transmitted order 0x10..0x14, with no byte lost or duplicated.
REQ-026 mode=1 with a core OUT 0x55 asserted in the same cycle as the loader push -> 0xAA transmitted first, then 0x55.
